// File: rtl/state_uart_tx_if.sv
// Handshake bundle for the serial readback transmitter: one parallel word
// offered with valid, taken when ready is high on the same rising edge.
interface state_uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_in;
   logic                 valid;
   logic                 ready;

   // producer side drives the word, transmitter answers with ready
   modport master (output data_in, output valid, input ready);
   modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/state_uart_tx.sv
// Serial readback transmitter: takes one word through a valid/ready
// handshake and shifts it out as an async UART frame
// (start, data LSB first, optional parity, stop). tx is registered and
// idles high; every bit lasts exactly CLKS_PER_BIT cycles.
module state_uart_tx #(
   parameter int CLKS_PER_BIT = 16,  // >= 2
   parameter int DATA_BITS    = 8,   // 5..8
   parameter int PARITY       = 0    // 0 none, 1 even, 2 odd
) (
   input  logic              clk,
   input  logic              rst_n,
   state_uart_tx_if.slave    bus,
   output logic              tx,
   output logic              busy
);

   localparam int CYC_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [BIT_W-1:0]     bitc_q, bitc_d;
   logic                 par_q, par_d;
   logic                 tx_d;

   logic ready;
   logic accept;
   logic cyc_end;
   logic last_bit;

   assign ready    = (state_q == S_IDLE);
   assign bus.ready = ready;
   assign busy     = !ready;
   assign accept   = bus.valid && ready;
   assign cyc_end  = (cyc_q == CYC_LAST);
   assign last_bit = (bitc_q == BIT_LAST);

   // state register; reset drops any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state: each non-idle state lasts whole bit periods
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.valid) state_d = S_START;
         S_START:  if (cyc_end) state_d = S_DATA;
         S_DATA:   if (cyc_end && last_bit)
                      state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (cyc_end) state_d = S_STOP;
         S_STOP:   if (cyc_end) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // datapath next values: latch word and parity on accept, then count
   // cycles within a bit and shift after each data bit
   always_comb begin
      shreg_d = shreg_q;
      cyc_d   = cyc_q;
      bitc_d  = bitc_q;
      par_d   = par_q;
      if (accept) begin
         shreg_d = bus.data_in;
         cyc_d   = '0;
         bitc_d  = '0;
         par_d   = (^bus.data_in) ^ ODD;
      end else if (state_q != S_IDLE) begin
         cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
         if (state_q == S_DATA && cyc_end) begin
            shreg_d = shreg_q >> 1;
            bitc_d  = bitc_q + 1'b1;
         end
      end
   end

   // output decode from the upcoming state so tx lands in a register
   // and falls on the very edge that accepts the word
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = par_d;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   // datapath and serial line registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cyc_q   <= '0;
         bitc_q  <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
      end else begin
         shreg_q <= shreg_d;
         cyc_q   <= cyc_d;
         bitc_q  <= bitc_d;
         par_q   <= par_d;
         tx      <= tx_d;
      end
   end

endmodule

// File: tb/tb_state_uart_tx.sv
// Directed bench for state_uart_tx: three instances (no/even/odd parity)
// at 4 clocks per bit, frames captured on the falling edge.
module tb_state_uart_tx;

   localparam int CPB = 4;

   logic       clk;
   logic       rst_n;
   logic [2:0] vld;
   logic [7:0] din;
   logic       tx_a   [3];
   logic       rdy_a  [3];
   logic       busy_a [3];

   int n_chk = 0;
   int n_err = 0;

   state_uart_tx_if #(.DATA_BITS(8)) if0 ();
   state_uart_tx_if #(.DATA_BITS(8)) if1 ();
   state_uart_tx_if #(.DATA_BITS(8)) if2 ();

   assign if0.valid = vld[0];
   assign if1.valid = vld[1];
   assign if2.valid = vld[2];
   assign if0.data_in = din;
   assign if1.data_in = din;
   assign if2.data_in = din;
   assign rdy_a[0] = if0.ready;
   assign rdy_a[1] = if1.ready;
   assign rdy_a[2] = if2.ready;

   state_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(if0), .tx(tx_a[0]), .busy(busy_a[0]));
   state_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .tx(tx_a[1]), .busy(busy_a[1]));
   state_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(if2), .tx(tx_a[2]), .busy(busy_a[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer w to instance s, then sample nb bit periods; bits[j] is the first
   // sample of bit j, jit counts samples that differ within a bit.
   task automatic run_frame(input int s, input logic [7:0] w, input int nb, input bit noise,
                            output logic [15:0] bits, output int rlow, output int bhi,
                            output int jit);
      bits = '0; rlow = 0; bhi = 0; jit = 0;
      @(negedge clk);
      din = w;
      vld[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[s] = 1'b0;
      for (int k = 0; k < nb * CPB; k++) begin
         if (k % CPB == 0) bits[k / CPB] = tx_a[s];
         else if (tx_a[s] !== bits[k / CPB]) jit++;
         if (!rdy_a[s]) rlow++;
         if (busy_a[s]) bhi++;
         if (noise) begin
            din = (k == 8) ? 8'h99 : ~din;
            vld[s] = (k >= 8 && k < 13);
         end
         @(negedge clk);
      end
      vld[s] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] bits;
      logic [81:0] tr;
      logic [9:0]  f1, f2;
      int rlow, bhi, jit, bad;

      rst_n = 1'b0;
      vld   = '0;
      din   = '0;

      // reset with random inputs
      repeat (6) begin
         @(negedge clk);
         vld = 3'($urandom);
         din = 8'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_tx%0d", i), tx_a[i], 1'b1);
         chk($sformatf("rst_ready%0d", i), rdy_a[i], 1'b1);
         chk($sformatf("rst_busy%0d", i), busy_a[i], 1'b0);
      end
      vld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) if (tx_a[i] !== 1'b1 || rdy_a[i] !== 1'b1) bad++;
      end
      chk("idle_after_reset", bad, 0);

      // single frame 0xA5: 0,1,0,1,0,0,1,0,1,1
      run_frame(0, 8'hA5, 10, 1'b0, bits, rlow, bhi, jit);
      chk("a5_bits", bits[9:0], 10'h34A);
      chk("a5_ready_low", rlow, 40);
      chk("a5_busy_high", bhi, 40);
      chk("a5_jitter", jit, 0);
      chk("a5_ready_after", rdy_a[0], 1'b1);
      chk("a5_tx_after", tx_a[0], 1'b1);

      // back-to-back 0x00 then 0xFF with valid held
      @(negedge clk);
      din = 8'h00;
      vld[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din = 8'hFF;
      for (int k = 0; k < 82; k++) begin
         tr[k] = tx_a[0];
         if (k == 41) vld[0] = 1'b0;
         @(negedge clk);
      end
      for (int j = 0; j < 10; j++) begin
         f1[j] = tr[j * CPB];
         f2[j] = tr[41 + j * CPB];
      end
      chk("b2b_frame1", f1, 10'h200);
      chk("b2b_gap_idle", tr[40], 1'b1);
      chk("b2b_frame2_start", tr[41], 1'b0);
      chk("b2b_frame2", f2, 10'h3FE);
      chk("b2b_end_idle", tr[81], 1'b1);
      repeat (3) @(negedge clk);
      chk("b2b_ready", rdy_a[0], 1'b1);

      // valid and data noise while busy must not disturb the frame
      run_frame(0, 8'h3C, 10, 1'b1, bits, rlow, bhi, jit);
      chk("busy_bits", bits[9:0], 10'h278);
      chk("busy_ready_low", rlow, 40);
      chk("busy_jitter", jit, 0);
      bad = 0;
      repeat (12) begin
         if (tx_a[0] !== 1'b1 || rdy_a[0] !== 1'b1) bad++;
         @(negedge clk);
      end
      chk("busy_no_second", bad, 0);

      // parity variants, 11 bit periods
      run_frame(1, 8'h07, 11, 1'b0, bits, rlow, bhi, jit);
      chk("even07_bits", bits[10:0], 11'h60E);
      chk("even07_ready_low", rlow, 44);
      chk("even07_jitter", jit, 0);
      run_frame(2, 8'h07, 11, 1'b0, bits, rlow, bhi, jit);
      chk("odd07_bits", bits[10:0], 11'h40E);
      chk("odd07_ready_low", rlow, 44);
      run_frame(1, 8'h00, 11, 1'b0, bits, rlow, bhi, jit);
      chk("even00_bits", bits[10:0], 11'h400);
      chk("even00_busy_high", bhi, 44);
      chk("even_ready_after", rdy_a[1], 1'b1);

      // reset during data bit 3 of 0x0F
      @(negedge clk);
      din = 8'h0F;
      vld[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("midrst_busy_before", busy_a[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx", tx_a[0], 1'b1);
      chk("midrst_ready", rdy_a[0], 1'b1);
      chk("midrst_busy", busy_a[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready_release", rdy_a[0], 1'b1);
      run_frame(0, 8'h55, 10, 1'b0, bits, rlow, bhi, jit);
      chk("post_rst_55_bits", bits[9:0], 10'h2AA);
      chk("post_rst_55_ready_low", rlow, 40);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
